// File: rtl/chip_inv_pkg.sv
// Shared encodings and screen constants for the invader formation logic.
package chip_inv_pkg;

  typedef enum logic {
    DIR_LEFT  = 1'b0,
    DIR_RIGHT = 1'b1
  } dir_t;

  typedef enum logic {
    MARCH  = 1'b0,
    LANDED = 1'b1
  } march_state_t;

  localparam int unsigned SCREEN_W = 640;
  localparam int unsigned SCREEN_H = 480;
  localparam int unsigned POS_W    = 10;

endpackage

// File: rtl/march_step_timer.sv
// Frame counter for the formation march; pulses step_evt_c on the frame that completes a period.
// Optional: MARCH_SPEEDUP_EN shortens the period as aliens die.
module march_step_timer
  import chip_inv_pkg::*;
#(
  parameter int unsigned STEP_FRAMES = 40,
  parameter int unsigned MIN_FRAMES  = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       restart,
  input  logic       frame_tick,
  input  logic       enable,
  input  logic       run,
  input  logic [5:0] alive_count,
  output logic       step_evt_c
);

  localparam int unsigned CNT_W = $clog2(STEP_FRAMES + 64);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [CNT_W-1:0] w_period;
  logic             w_count_en;

`ifdef MARCH_SPEEDUP_EN
  // Period tracks the live alien count, clamped to [MIN_FRAMES, STEP_FRAMES].
  logic [CNT_W-1:0] w_alive;
  assign w_alive = CNT_W'(alive_count);

  always_comb begin
    w_period = CNT_W'(STEP_FRAMES);
    if (w_alive < w_period) w_period = w_alive;
    if (w_period < CNT_W'(MIN_FRAMES)) w_period = CNT_W'(MIN_FRAMES);
  end
`else
  assign w_period = CNT_W'(STEP_FRAMES);
`endif

  assign w_count_en = frame_tick & enable & run & (alive_count != 6'd0);
  // >= so a shrinking period fires on the very next counted frame.
  assign step_evt_c = w_count_en & (r_cnt >= (w_period - CNT_W'(1)));

  always_comb begin
    w_cnt_nxt = r_cnt;
    if (restart)         w_cnt_nxt = '0;
    else if (step_evt_c) w_cnt_nxt = '0;
    else if (w_count_en) w_cnt_nxt = r_cnt + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_cnt <= '0;
    else        r_cnt <= w_cnt_nxt;
  end

endmodule

// File: rtl/alien_march_ctrl.sv
// Formation march controller: shared direction and x/y offsets, edge bounce with descent, landing detect.
// Optional: MARCH_SPEEDUP_EN (step period follows alive_count).
module alien_march_ctrl
  import chip_inv_pkg::*;
#(
  parameter int unsigned STEP_FRAMES = 40,
  parameter int unsigned STEP_X      = 2,
  parameter int unsigned STEP_Y      = 8,
  parameter int unsigned X_MIN       = 0,
  parameter int unsigned X_MAX       = 440,
  parameter int unsigned Y_MAX       = 320,
  parameter int unsigned MIN_FRAMES  = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_tick,
  input  logic       enable,
  input  logic       restart,
  input  logic [5:0] alive_count,
  output logic [9:0] x_off,
  output logic [9:0] y_off,
  output logic       dir,
  output logic       step,
  output logic       invaded
);

  // Offsets are 10-bit; the parameter set must not let an update wrap.
  if ((X_MAX + STEP_X) >= 1024 || (Y_MAX + STEP_Y) >= 1024) begin : g_param_check
    $error("alien_march_ctrl: X_MAX+STEP_X and Y_MAX+STEP_Y must be below 1024");
  end

  march_state_t     r_state, w_state_nxt;
  dir_t             r_dir, w_dir_nxt;
  logic [POS_W-1:0] r_x, w_x_nxt;
  logic [POS_W-1:0] r_y, w_y_nxt;
  logic             r_step, w_step_nxt;
  logic             r_invaded, w_invaded_nxt;
  logic             w_step_evt;
  logic [POS_W-1:0] w_y_desc;

  march_step_timer #(
    .STEP_FRAMES (STEP_FRAMES),
    .MIN_FRAMES  (MIN_FRAMES)
  ) u_timer (
    .clk         (clk),
    .rst_n       (rst_n),
    .restart     (restart),
    .frame_tick  (frame_tick),
    .enable      (enable),
    .run         (r_state == MARCH),
    .alive_count (alive_count),
    .step_evt_c  (w_step_evt)
  );

  assign w_y_desc = r_y + POS_W'(STEP_Y);

  always_comb begin
    w_state_nxt   = r_state;
    w_dir_nxt     = r_dir;
    w_x_nxt       = r_x;
    w_y_nxt       = r_y;
    w_step_nxt    = 1'b0;
    w_invaded_nxt = r_invaded;
    if (restart) begin
      w_state_nxt   = MARCH;
      w_dir_nxt     = DIR_RIGHT;
      w_x_nxt       = POS_W'(X_MIN);
      w_y_nxt       = '0;
      w_invaded_nxt = 1'b0;
    end else if (r_state == MARCH && w_step_evt) begin
      w_step_nxt = 1'b1;
      // A bounce spends the whole step on the descent.
      if (r_dir == DIR_RIGHT) begin
        if ((r_x + POS_W'(STEP_X)) > POS_W'(X_MAX)) begin
          w_y_nxt   = w_y_desc;
          w_dir_nxt = DIR_LEFT;
        end else begin
          w_x_nxt = r_x + POS_W'(STEP_X);
        end
      end else begin
        if (r_x < POS_W'(X_MIN + STEP_X)) begin
          w_y_nxt   = w_y_desc;
          w_dir_nxt = DIR_RIGHT;
        end else begin
          w_x_nxt = r_x - POS_W'(STEP_X);
        end
      end
      if (w_y_nxt >= POS_W'(Y_MAX)) begin
        w_state_nxt   = LANDED;
        w_invaded_nxt = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= MARCH;
      r_dir     <= DIR_RIGHT;
      r_x       <= POS_W'(X_MIN);
      r_y       <= '0;
      r_step    <= 1'b0;
      r_invaded <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_dir     <= w_dir_nxt;
      r_x       <= w_x_nxt;
      r_y       <= w_y_nxt;
      r_step    <= w_step_nxt;
      r_invaded <= w_invaded_nxt;
    end
  end

  assign x_off   = r_x;
  assign y_off   = r_y;
  assign dir     = r_dir;
  assign step    = r_step;
  assign invaded = r_invaded;

endmodule

// File: tb/tb_alien_march_ctrl.sv
// Self-checking bench for alien_march_ctrl: per-cycle model compare plus directed literal checks.
// X_MAX is narrowed so the landing scenario fits a short run.
module tb_alien_march_ctrl;

  localparam int P_STEP_FRAMES = 40;
  localparam int P_STEP_X      = 2;
  localparam int P_STEP_Y      = 8;
  localparam int P_X_MIN       = 0;
  localparam int P_X_MAX       = 40;
  localparam int P_Y_MAX       = 320;
  localparam int P_MIN_FRAMES  = 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       frame_tick;
  logic       enable;
  logic       restart;
  logic [5:0] alive_count;
  logic [9:0] x_off;
  logic [9:0] y_off;
  logic       dir;
  logic       step;
  logic       invaded;

  int checks = 0;
  int errors = 0;
  int dut_steps = 0;

  alien_march_ctrl #(
    .STEP_FRAMES (P_STEP_FRAMES),
    .STEP_X      (P_STEP_X),
    .STEP_Y      (P_STEP_Y),
    .X_MIN       (P_X_MIN),
    .X_MAX       (P_X_MAX),
    .Y_MAX       (P_Y_MAX),
    .MIN_FRAMES  (P_MIN_FRAMES)
  ) u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .frame_tick  (frame_tick),
    .enable      (enable),
    .restart     (restart),
    .alive_count (alive_count),
    .x_off       (x_off),
    .y_off       (y_off),
    .dir         (dir),
    .step        (step),
    .invaded     (invaded)
  );

  always #5 clk = ~clk;

  // Behavioural model: frames since last step, position, heading, landed flag.
  int m_x, m_y, m_dir, m_step, m_landed, m_frames;

  function automatic int period_of(input int alive);
`ifdef MARCH_SPEEDUP_EN
    int p;
    p = (alive < P_STEP_FRAMES) ? alive : P_STEP_FRAMES;
    return (p < P_MIN_FRAMES) ? P_MIN_FRAMES : p;
`else
    return P_STEP_FRAMES;
`endif
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_x = P_X_MIN; m_y = 0; m_dir = 1; m_step = 0; m_landed = 0; m_frames = 0;
    end else begin
      m_step = 0;
      if (restart) begin
        m_x = P_X_MIN; m_y = 0; m_dir = 1; m_landed = 0; m_frames = 0;
      end else if (!m_landed && enable && alive_count != 0 && frame_tick) begin
        m_frames = m_frames + 1;
        if (m_frames >= period_of(int'(alive_count))) begin
          m_frames = 0;
          m_step = 1;
          if (m_dir == 1) begin
            if (m_x + P_STEP_X > P_X_MAX) begin m_y = m_y + P_STEP_Y; m_dir = 0; end
            else m_x = m_x + P_STEP_X;
          end else begin
            if (m_x < P_X_MIN + P_STEP_X) begin m_y = m_y + P_STEP_Y; m_dir = 1; end
            else m_x = m_x - P_STEP_X;
          end
          if (m_y >= P_Y_MAX) m_landed = 1;
        end
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle compare against the model, just after each active edge.
  always @(posedge clk) begin
    #1;
    if (step) dut_steps++;
    check("model_x_off", int'(x_off), m_x);
    check("model_y_off", int'(y_off), m_y);
    check("model_dir", int'(dir), m_dir);
    check("model_step", int'(step), m_step);
    check("model_invaded", int'(invaded), m_landed);
  end

  // Drives frame_tick high for exactly n rising edges; called and returns at a falling edge.
  task automatic ticks(input int n);
    if (n > 0) begin
      frame_tick = 1'b1;
      repeat (n) @(negedge clk);
      frame_tick = 1'b0;
    end
  endtask

  int s0;
  int waited;

  initial begin
    rst_n = 1'b0; frame_tick = 1'b0; enable = 1'b0; restart = 1'b0; alive_count = 6'd40;
    #12;
    check("rst_x", int'(x_off), 0);
    check("rst_y", int'(y_off), 0);
    check("rst_dir", int'(dir), 1);
    check("rst_step", int'(step), 0);
    check("rst_invaded", int'(invaded), 0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);

    // 1: first step after 40 frames
    enable = 1'b1;
    s0 = dut_steps;
    ticks(39);
    check("t1_no_early_step", dut_steps - s0, 0);
    ticks(1);
    check("t1_step_pulse", int'(step), 1);
    check("t1_steps", dut_steps - s0, 1);
    check("t1_x", int'(x_off), 2);
    check("t1_dir", int'(dir), 1);

    // 2: right-edge bounce
    ticks(19 * P_STEP_FRAMES);
    check("t2_x_edge", int'(x_off), 40);
    check("t2_dir_edge", int'(dir), 1);
    ticks(P_STEP_FRAMES);
    check("t2_x_bounce", int'(x_off), 40);
    check("t2_y_bounce", int'(y_off), 8);
    check("t2_dir_bounce", int'(dir), 0);
    ticks(P_STEP_FRAMES);
    check("t2_x_after", int'(x_off), 38);

    // 3: march down to the landing line
    frame_tick = 1'b1;
    waited = 0;
    while (!invaded && waited < 60000) begin
      @(negedge clk);
      waited++;
    end
    frame_tick = 1'b0;
    check("t3_landed_in_time", int'(invaded), 1);
    check("t3_y_landed", int'(y_off), 320);
    s0 = dut_steps;
    ticks(200);
    check("t3_no_steps_landed", dut_steps - s0, 0);
    check("t3_invaded_sticky", int'(invaded), 1);
    restart = 1'b1; @(negedge clk); restart = 1'b0;
    check("t3_restart_x", int'(x_off), 0);
    check("t3_restart_y", int'(y_off), 0);
    check("t3_restart_dir", int'(dir), 1);
    check("t3_restart_inv", int'(invaded), 0);
    @(negedge clk);

    // 4: pause mid-count
    s0 = dut_steps;
    ticks(15);
    enable = 1'b0;
    ticks(100);
    check("t4_paused_steps", dut_steps - s0, 0);
    check("t4_paused_x", int'(x_off), 0);
    enable = 1'b1;
    ticks(24);
    check("t4_remaining_no_step", dut_steps - s0, 0);
    ticks(1);
    check("t4_resume_step", dut_steps - s0, 1);
    check("t4_resume_x", int'(x_off), 2);

    // 5: restart beats a due step; async reset mid-count
    ticks(39);
    restart = 1'b1; frame_tick = 1'b1;
    @(negedge clk);
    restart = 1'b0; frame_tick = 1'b0;
    check("t5_restart_x", int'(x_off), 0);
    check("t5_restart_step", int'(step), 0);
    check("t5_restart_dir", int'(dir), 1);
    ticks(P_STEP_FRAMES);
    check("t5_x_before_rst", int'(x_off), 2);
    ticks(10);
    rst_n = 1'b0;
    #1;
    check("t5_async_x", int'(x_off), 0);
    check("t5_async_step", int'(step), 0);
    check("t5_async_dir", int'(dir), 1);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);

    // 6: period versus alive_count
    s0 = dut_steps;
    alive_count = 6'd5;
`ifdef MARCH_SPEEDUP_EN
    ticks(4);
    check("t6_a5_early", dut_steps - s0, 0);
    ticks(1);
    check("t6_a5_step", dut_steps - s0, 1);
    ticks(5);
    check("t6_a5_step2", dut_steps - s0, 2);
    alive_count = 6'd1;
    ticks(1);
    check("t6_a1_early", dut_steps - s0, 2);
    ticks(1);
    check("t6_a1_step", dut_steps - s0, 3);
    ticks(2);
    check("t6_a1_step2", dut_steps - s0, 4);
`else
    ticks(39);
    check("t6_a5_no_speedup", dut_steps - s0, 0);
    ticks(1);
    check("t6_a5_step40", dut_steps - s0, 1);
`endif
    s0 = dut_steps;
    alive_count = 6'd0;
    ticks(100);
    check("t6_a0_frozen", dut_steps - s0, 0);
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
